// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
//
// Instruction fetch front end for a synchronous-read instruction memory.
// A fetch PC (fpc) drives the memory address directly; the word returns one
// cycle later and is pushed, together with its address, into a 2-entry FIFO
// whose head is presented to decode. Issue is throttled so that the FIFO can
// never overflow, even counting the word that is still in flight. A redirect
// flushes everything buffered or in flight and restarts fetch at a new PC.
//
// Ports
//   clk            : single clock, rising edge
//   reset          : asynchronous, active-high
//   mem_address    : word address presented to the instruction memory (= fpc)
//   mem_read       : high in every cycle a fetch is issued
//   mem_data       : memory word, valid the cycle after its address
//   redirect_valid : one-cycle request to restart fetch at redirect_pc
//   redirect_pc    : new fetch address (bits [1:0] ignored)
//   out_valid      : instruction presented to decode
//   out_ready      : decode accepts (transfer when out_valid & out_ready)
//   out_instr      : instruction word at the FIFO head
//   out_pc         : address of out_instr
//
// Handshake: out_valid/out_ready follow strict valid/ready rules -- a transfer
// happens on any rising edge where both are high; while out_valid is high and
// out_ready is low the head entry (out_instr/out_pc) is held unchanged, and
// out_valid does not depend on out_ready.
// -----------------------------------------------------------------------------
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] mem_address,
    output logic        mem_read,
    input  logic [31:0] mem_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc
);

    // Fetch state
    logic [31:0] fpc_q, fpc_d;
    logic        inflight_q, inflight_d;
    logic [31:0] inflight_pc_q, inflight_pc_d;

    // 2-entry FIFO
    logic [31:0] instr_q [2];
    logic [31:0] instr_d [2];
    logic [31:0] pc_q    [2];
    logic [31:0] pc_d    [2];
    logic        rd_ptr_q, rd_ptr_d;
    logic        wr_ptr_q, wr_ptr_d;
    logic [1:0]  count_q, count_d;

    logic        pop;
    logic        push;
    logic        issue;
    logic [2:0]  occ_next;

    // The low address bits of a redirect target are dropped by design.
    logic [1:0]  unused_redirect_lsbs;
    assign unused_redirect_lsbs = redirect_pc[1:0];

    assign out_valid   = (count_q != 2'd0);
    assign out_instr   = instr_q[rd_ptr_q];
    assign out_pc      = pc_q[rd_ptr_q];
    assign mem_address = fpc_q;
    assign mem_read    = issue;

    assign pop  = out_valid & out_ready;
    // A response arriving in a redirect cycle belongs to the old stream.
    assign push = inflight_q & ~redirect_valid;

    // Occupancy the FIFO will reach once the in-flight word lands and the
    // current pop retires. Issuing only when this is below 2 guarantees a free
    // slot for the word issued now when it returns next cycle. A pop implies
    // count >= 1, so the subtraction never underflows.
    assign occ_next = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop};

    // Reset is included so mem_read drops the moment reset asserts.
    assign issue = ~reset & ~redirect_valid & (occ_next < 3'd2);

    always_comb begin
        fpc_d         = fpc_q;
        inflight_d    = issue;
        inflight_pc_d = inflight_pc_q;
        instr_d       = instr_q;
        pc_d          = pc_q;
        rd_ptr_d      = rd_ptr_q;
        wr_ptr_d      = wr_ptr_q;
        count_d       = count_q;

        if (redirect_valid) begin
            // Redirect wins over push, pop and issue. A pop in this cycle is
            // still a valid transfer of the head; the flush simply discards
            // whatever remains.
            fpc_d    = {redirect_pc[31:2], 2'b00};
            rd_ptr_d = 1'b0;
            wr_ptr_d = 1'b0;
            count_d  = 2'd0;
        end else begin
            if (issue) begin
                fpc_d         = fpc_q + 32'd4;   // wraps modulo 2^32
                inflight_pc_d = fpc_q;
            end
            if (push) begin
                instr_d[wr_ptr_q] = mem_data;
                pc_d[wr_ptr_q]    = inflight_pc_q;
                wr_ptr_d          = ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_d = ~rd_ptr_q;
            end
            count_d = count_q + {1'b0, push} - {1'b0, pop};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fpc_q         <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= 32'h0;
            instr_q[0]    <= 32'h0;
            instr_q[1]    <= 32'h0;
            pc_q[0]       <= 32'h0;
            pc_q[1]       <= 32'h0;
            rd_ptr_q      <= 1'b0;
            wr_ptr_q      <= 1'b0;
            count_q       <= 2'd0;
        end else begin
            fpc_q         <= fpc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
            instr_q[0]    <= instr_d[0];
            instr_q[1]    <= instr_d[1];
            pc_q[0]       <= pc_d[0];
            pc_q[1]       <= pc_d[1];
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
            count_q       <= count_d;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_unit
//
// Directed bench for fetch_unit. Memory model: synchronous read, the word at
// byte address a is a[9:2] (so word i = i for small i, and 0xFFFFFFFC reads
// 255). One table row per clock cycle: inputs applied #1 after the rising
// edge, outputs sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_fetch_unit;

    logic        clk;
    logic        reset;
    logic [31:0] mem_address;
    logic        mem_read;
    logic [31:0] mem_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;

    int tests_run;
    int tests_failed;

    fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk            (clk),
        .reset          (reset),
        .mem_address    (mem_address),
        .mem_read       (mem_read),
        .mem_data       (mem_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instr      (out_instr),
        .out_pc         (out_pc)
    );

    // Clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Synchronous-read instruction memory
    always @(posedge clk) begin
        mem_data <= {24'h0, mem_address[9:2]};
    end

    typedef struct {
        logic        rdy;
        logic        rv;
        logic [31:0] rpc;
        logic        valid;
        logic [31:0] pc;
        logic [31:0] instr;
        logic        mr;
        logic [31:0] addr;
    } vec_t;

    localparam int NV = 27;
    vec_t vecs [NV];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic set_vec(input int i, input logic rdy, input logic rv, input logic [31:0] rpc,
                           input logic valid, input logic [31:0] pc, input logic [31:0] instr,
                           input logic mr, input logic [31:0] addr);
        vecs[i].rdy   = rdy;
        vecs[i].rv    = rv;
        vecs[i].rpc   = rpc;
        vecs[i].valid = valid;
        vecs[i].pc    = pc;
        vecs[i].instr = instr;
        vecs[i].mr    = mr;
        vecs[i].addr  = addr;
    endtask

    // Sample outputs for one cycle and compare with expectations.
    task automatic check_cycle(input string tag, input logic valid, input logic [31:0] pc,
                               input logic [31:0] instr, input logic mr, input logic [31:0] addr);
        chk($sformatf("%s out_valid", tag), {31'h0, out_valid}, {31'h0, valid});
        chk($sformatf("%s mem_read", tag), {31'h0, mem_read}, {31'h0, mr});
        if (valid) begin
            chk($sformatf("%s out_pc", tag), out_pc, pc);
            chk($sformatf("%s out_instr", tag), out_instr, instr);
        end
        if (mr) begin
            chk($sformatf("%s mem_address", tag), mem_address, addr);
        end
    endtask

    task automatic check_reset_state(input string tag);
        chk($sformatf("%s out_valid", tag), {31'h0, out_valid}, 32'h0);
        chk($sformatf("%s mem_read", tag), {31'h0, mem_read}, 32'h0);
        chk($sformatf("%s out_pc", tag), out_pc, 32'h0);
        chk($sformatf("%s out_instr", tag), out_instr, 32'h0);
        chk($sformatf("%s mem_address", tag), mem_address, 32'h0);
    endtask

    initial begin
        tests_run      = 0;
        tests_failed   = 0;
        reset          = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        out_ready      = 1'b1;

        //          rdy rv  rpc           vld pc            instr        mr addr
        set_vec( 0, 1, 0, 32'h0,        0, 32'h0,        32'h0,   1, 32'h0);
        set_vec( 1, 1, 0, 32'h0,        0, 32'h0,        32'h0,   1, 32'h4);
        // decode stalls: FIFO fills to 2, issue stops, head held
        set_vec( 2, 0, 0, 32'h0,        1, 32'h0,        32'h0,   0, 32'h0);
        set_vec( 3, 0, 0, 32'h0,        1, 32'h0,        32'h0,   0, 32'h0);
        set_vec( 4, 0, 0, 32'h0,        1, 32'h0,        32'h0,   0, 32'h0);
        set_vec( 5, 0, 0, 32'h0,        1, 32'h0,        32'h0,   0, 32'h0);
        set_vec( 6, 0, 0, 32'h0,        1, 32'h0,        32'h0,   0, 32'h0);
        // release: sequence continues with no gap or repeat
        set_vec( 7, 1, 0, 32'h0,        1, 32'h0,        32'h0,   1, 32'h8);
        set_vec( 8, 1, 0, 32'h0,        1, 32'h4,        32'h1,   1, 32'hC);
        set_vec( 9, 1, 0, 32'h0,        1, 32'h8,        32'h2,   1, 32'h10);
        set_vec(10, 1, 0, 32'h0,        1, 32'hC,        32'h3,   1, 32'h14);
        // redirect to 0x40 while a word is in flight and the FIFO is occupied
        set_vec(11, 0, 1, 32'h40,       1, 32'h10,       32'h4,   0, 32'h0);
        set_vec(12, 1, 0, 32'h0,        0, 32'h0,        32'h0,   1, 32'h40);
        set_vec(13, 1, 0, 32'h0,        0, 32'h0,        32'h0,   1, 32'h44);
        set_vec(14, 1, 0, 32'h0,        1, 32'h40,       32'h10,  1, 32'h48);
        set_vec(15, 1, 0, 32'h0,        1, 32'h44,       32'h11,  1, 32'h4C);
        // unaligned redirect coincident with a pop
        set_vec(16, 1, 1, 32'h13,       1, 32'h48,       32'h12,  0, 32'h0);
        set_vec(17, 1, 0, 32'h0,        0, 32'h0,        32'h0,   1, 32'h10);
        set_vec(18, 1, 0, 32'h0,        0, 32'h0,        32'h0,   1, 32'h14);
        set_vec(19, 1, 0, 32'h0,        1, 32'h10,       32'h4,   1, 32'h18);
        set_vec(20, 1, 0, 32'h0,        1, 32'h14,       32'h5,   1, 32'h1C);
        // redirect to the top of the address space: PC wraps to 0
        set_vec(21, 1, 1, 32'hFFFFFFFC, 1, 32'h18,       32'h6,   0, 32'h0);
        set_vec(22, 1, 0, 32'h0,        0, 32'h0,        32'h0,   1, 32'hFFFFFFFC);
        set_vec(23, 1, 0, 32'h0,        0, 32'h0,        32'h0,   1, 32'h0);
        set_vec(24, 1, 0, 32'h0,        1, 32'hFFFFFFFC, 32'hFF,  1, 32'h4);
        set_vec(25, 1, 0, 32'h0,        1, 32'h0,        32'h0,   1, 32'h8);
        set_vec(26, 1, 0, 32'h0,        1, 32'h4,        32'h1,   1, 32'hC);

        // Reset state, before any clock edge has been seen
        #2;
        check_reset_state("reset_initial");
        repeat (3) @(posedge clk);
        #1;
        check_reset_state("reset_held");

        // Release reset just after an edge; table row 0 is this cycle
        @(posedge clk);
        #1;
        reset = 1'b0;
        for (int i = 0; i < NV; i++) begin
            if (i != 0) begin
                @(posedge clk);
                #1;
            end
            out_ready      = vecs[i].rdy;
            redirect_valid = vecs[i].rv;
            redirect_pc    = vecs[i].rpc;
            @(negedge clk);
            check_cycle($sformatf("vec%0d", i), vecs[i].valid, vecs[i].pc, vecs[i].instr,
                        vecs[i].mr, vecs[i].addr);
        end

        // Asynchronous reset mid-stream, between clock edges
        @(posedge clk);
        #1;
        redirect_valid = 1'b0;
        out_ready      = 1'b1;
        #2;
        reset = 1'b1;
        #1;
        check_reset_state("async_reset");
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check_cycle("post_reset0", 1'b0, 32'h0, 32'h0, 1'b1, 32'h0);
        @(posedge clk);
        #1;
        @(negedge clk);
        check_cycle("post_reset1", 1'b0, 32'h0, 32'h0, 1'b1, 32'h4);
        @(posedge clk);
        #1;
        @(negedge clk);
        check_cycle("post_reset2", 1'b1, 32'h0, 32'h0, 1'b1, 32'h8);
        @(posedge clk);
        #1;
        @(negedge clk);
        check_cycle("post_reset3", 1'b1, 32'h4, 32'h1, 1'b1, 32'hC);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
